// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg
// Shared definitions for the paced FIFO read-side drain controller:
//   drain_state_t : controller state encoding (IDLE, DELAY, DRAIN)
//   BYTE_W        : width of one FIFO / SiTCP byte lane
//   len_width()   : width needed to hold channels * bytes-per-channel
//                   without overflow

package fifo_drain_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      DRAIN = 2'd2
   } drain_state_t;

   // One extra bit beyond the product's natural width so the burst length
   // can never wrap, whatever channel count is requested.
   function automatic int len_width(input int ch_w, input int bytes_per_ch);
      return ch_w + $clog2(bytes_per_ch) + 1;
   endfunction

endpackage

// File: rtl/drain_delay_cnt.sv
// drain_delay_cnt
// Loadable down-counter with a terminal-count flag. Serves both as the
// post-trigger hold-off and as the DRAIN stall watchdog.
// Ports:
//   clk        : clock
//   reset      : asynchronous active-high reset (count cleared)
//   load       : load load_value (wins over dec)
//   load_value : value loaded into the counter
//   dec        : decrement by one; holds at zero
//   tc         : high while the count equals 1, i.e. the last counted cycle

module drain_delay_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == W'(1));

endmodule

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain
// Paced read-side controller between a standard (non-FWFT) FIFO read port
// and the SiTCP TX data interface. A trigger starts a hold-off of
// DELAY_CYCLES clocks, then exactly BYTES_PER_CH * rd_channels bytes are
// read and forwarded, honouring TCP backpressure and connection state.
// Optional feature macro: BURST_TIMEOUT_EN -- when defined, a DRAIN stall of
// TIMEOUT_CYCLES clocks without a read aborts the burst and pulses
// burst_err; when undefined, DRAIN waits indefinitely and burst_err is 0.
// Ports:
//   clk, reset     : read-side clock, asynchronous active-high reset
//   trigger        : burst request pulse
//   rd_channels    : channel count, sampled on an accepted trigger
//   fifo_empty     : FIFO empty flag
//   fifo_valid     : FIFO dout valid, one cycle after fifo_rd_en
//   fifo_dout      : FIFO data
//   tcp_open_ack   : SiTCP connection open
//   tcp_tx_full    : SiTCP TX backpressure
//   fifo_rd_en     : FIFO read strobe
//   tx_data        : byte to SiTCP
//   tx_data_en     : tx_data qualifier
//   busy           : high outside IDLE
//   trig_drop      : one-cycle pulse, trigger ignored
//   burst_err      : one-cycle pulse, burst aborted by stall timeout

module fifo_burst_drain
   import fifo_drain_pkg::*;
#(
   parameter int          DELAY_W        = 32,
   parameter int unsigned DELAY_CYCLES   = 1000000,
   parameter int          BYTES_PER_CH   = 4,
   parameter int          CH_W           = 4,
   parameter int          TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trigger,
   input  logic [CH_W-1:0]   rd_channels,
   input  logic              fifo_empty,
   input  logic              fifo_valid,
   input  logic [BYTE_W-1:0] fifo_dout,
   input  logic              tcp_open_ack,
   input  logic              tcp_tx_full,
   output logic              fifo_rd_en,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_data_en,
   output logic              busy,
   output logic              trig_drop,
   output logic              burst_err
);

   localparam int LEN_W = len_width(CH_W, BYTES_PER_CH);

   drain_state_t     state;
   drain_state_t     next_state;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] remaining;
   logic [1:0]       in_flight;
   logic             accept;
   logic             dly_tc;
   logic             timeout;

   assign len    = LEN_W'(BYTES_PER_CH) * LEN_W'(rd_channels);
   assign accept = (state == IDLE) && trigger && (len != '0);

   drain_delay_cnt #(
      .W (DELAY_W)
   ) u_delay (
      .clk        (clk),
      .reset      (reset),
      .load       (accept),
      .load_value (DELAY_W'(DELAY_CYCLES)),
      .dec        (state == DELAY),
      .tc         (dly_tc)
   );

`ifdef BURST_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic tmo_tc;

   // Reloaded on every read and whenever outside DRAIN; loading one less
   // than the limit makes tc land on the last permitted stall cycle.
   drain_delay_cnt #(
      .W (TMO_W)
   ) u_timeout (
      .clk        (clk),
      .reset      (reset),
      .load       ((state != DRAIN) || fifo_rd_en),
      .load_value (TMO_W'(TIMEOUT_CYCLES - 1)),
      .dec        ((state == DRAIN) && !fifo_rd_en),
      .tc         (tmo_tc)
   );

   assign timeout = (state == DRAIN) && !fifo_rd_en && tmo_tc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         burst_err <= 1'b0;
      end else begin
         burst_err <= timeout;
      end
   end
`else
   assign timeout   = 1'b0;
   assign burst_err = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. DRAIN only finishes once every issued read has
   // returned its byte, so busy covers the final forwarded byte.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = (DELAY_CYCLES == 0) ? DRAIN : DELAY;
            end
         end
         DELAY: begin
            if (dly_tc) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (timeout) begin
               next_state = IDLE;
            end else if ((remaining == '0) && (in_flight == 2'd0)) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      fifo_rd_en = 1'b0;
      busy       = (state != IDLE);
      if (state == DRAIN) begin
         fifo_rd_en = !fifo_empty && tcp_open_ack && !tcp_tx_full
                      && (remaining != '0);
      end
   end

   // Bytes still to be read in the current burst
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining <= '0;
      end else if (accept) begin
         remaining <= len;
      end else if (fifo_rd_en) begin
         remaining <= remaining - 1'b1;
      end
   end

   // Reads issued whose fifo_valid has not yet come back
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_flight <= 2'd0;
      end else begin
         case ({fifo_rd_en, fifo_valid})
            2'b10: in_flight <= in_flight + 2'd1;
            2'b01: if (in_flight != 2'd0) in_flight <= in_flight - 2'd1;
            default: ;
         endcase
      end
   end

   // Forwarding is unconditional so bytes already in flight when
   // backpressure rises or a timeout fires are never lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_data    <= '0;
         tx_data_en <= 1'b0;
         trig_drop  <= 1'b0;
      end else begin
         tx_data    <= fifo_dout;
         tx_data_en <= fifo_valid;
         trig_drop  <= trigger && !accept;
      end
   end

endmodule

// File: doc/fifo_burst_drain.md
# fifo_burst_drain

Paced read-side controller for the ADC transmit FIFO, generalising the fixed read-delay counter used in the I2C/MAX1238 readout chain. Each write-side trigger starts a programmable hold-off, then drains exactly BYTES_PER_CH × channel-count bytes from a first-word-fall-through-free (standard) FIFO into the SiTCP transmit path. The drain obeys TCP backpressure and connection state. Sits between the FIFO generator's read port and the SiTCP TX data interface, in the read-clock domain.

## Interface

- DELAY_W, 32: hold-off counter width
- DELAY_CYCLES, 1000000: hold-off after trigger, in clk cycles (5 ms at 200 MHz); 0 means no hold-off
- BYTES_PER_CH, 4: bytes per channel per burst
- CH_W, 4: channel-count width
- TIMEOUT_CYCLES, 4096: stall limit in DRAIN, used only with the timeout feature

- clk  in  1  read-side clock
- reset  in  1  asynchronous, active-high
- trigger  in  1  burst request pulse, synchronous to clk
- rd_channels  in  CH_W  channels in this burst, sampled on accepted trigger
- fifo_empty  in  1  FIFO empty flag
- fifo_valid  in  1  FIFO dout valid (one cycle after rd_en)
- fifo_dout  in  8  FIFO data
- tcp_open_ack  in  1  SiTCP connection open
- tcp_tx_full  in  1  SiTCP TX backpressure
- fifo_rd_en  out  1  FIFO read strobe
- tx_data  out  8  byte to SiTCP
- tx_data_en  out  1  tx_data qualifier
- busy  out  1  high outside IDLE
- trig_drop  out  1  one-cycle pulse: trigger ignored
- burst_err  out  1  one-cycle pulse: burst aborted

## Operation

- States: IDLE, DELAY, DRAIN.
- IDLE: on trigger, latch len = BYTES_PER_CH × rd_channels (width CH_W+clog2(BYTES_PER_CH)+1, no overflow). If len = 0: stay IDLE, pulse trig_drop. Else load delay counter with DELAY_CYCLES; go to DELAY (or straight to DRAIN if DELAY_CYCLES = 0).
- DELAY: decrement each cycle; at count reaching 1, go to DRAIN next cycle. Trigger ignored with trig_drop pulse.
- DRAIN: fifo_rd_en = !fifo_empty && tcp_open_ack && !tcp_tx_full && remaining > 0. remaining decrements on each fifo_rd_en cycle. Return to IDLE when remaining = 0 and no read is outstanding (last fifo_valid consumed).
- Forwarding: tx_data <= fifo_dout, tx_data_en <= fifo_valid, registered. Output bytes equal read strobes exactly; no byte dropped or duplicated.
- fifo_valid arriving while tcp_tx_full rose: byte still forwarded (SiTCP TX_FULL tolerates in-flight bytes); stall begins the following strobe.
- Trigger in DRAIN: ignored, trig_drop pulse. Trigger coinciding with DRAIN→IDLE transition: ignored.
- tcp_open_ack low during DRAIN: reads pause; burst resumes when it returns (unless timeout).

## Timing

- Reset values: fifo_rd_en 0, tx_data 0, tx_data_en 0, busy 0, trig_drop 0, burst_err 0; state IDLE, counters 0. Reset mid-burst aborts immediately; unread FIFO bytes remain in the FIFO.
- Trigger to first fifo_rd_en: DELAY_CYCLES + 1 cycles, given FIFO non-empty and no backpressure.
- fifo_rd_en to tx_data_en: 2 cycles (1 FIFO + 1 register).
- Unstalled burst: len consecutive fifo_rd_en cycles.
- busy rises the cycle after trigger; falls the cycle after the last tx_data_en.

## Configuration

- BURST_TIMEOUT_EN defined: in DRAIN, a stall counter resets on each read and counts cycles without one. Reaching TIMEOUT_CYCLES forces IDLE with a one-cycle burst_err pulse. Outstanding valid bytes are still forwarded.
- Undefined: no stall counter; DRAIN waits indefinitely; burst_err tied 0.

## Structure

- Shared package fifo_drain_pkg: state enum (IDLE, DELAY, DRAIN), byte width constant 8, length-width function.
- One sub-module: drain_delay_cnt, a loadable down-counter with a terminal-count output, reused for the hold-off and the timeout.

## Test plan

- DELAY_CYCLES = 20, rd_channels = 3, FIFO preloaded with 12 bytes 0x00..0x0B, no backpressure -> first fifo_rd_en 21 cycles after trigger; 12 consecutive strobes; tx_data 0x00..0x0B in order; busy low afterwards.
- Same setup with tcp_tx_full high for 5 cycles mid-burst -> strobes pause; total 12 bytes, order intact, no duplicates.
- rd_channels = 0 trigger -> trig_drop pulse; busy stays 0; no strobes.
- Second trigger during DELAY and during DRAIN -> trig_drop pulse each; only 12 bytes sent.
- BURST_TIMEOUT_EN, TIMEOUT_CYCLES = 16, only 5 bytes in FIFO for a 12-byte burst -> 5 bytes out; burst_err 16 cycles after the last strobe; IDLE.
- Reset asserted mid-DRAIN after 6 bytes -> all outputs 0 immediately; after release, a new trigger runs a full burst.
